// File: rtl/lc3b_types.sv
// Shared types for the L1/L2 cache arbiter.
// Holds the cache line type and the arbiter FSM state encoding.
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DONE
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_datapath.sv
// Combinational L2 request mux and rdata/resp demux for the arbiter.
// Only the selected requester sees L2 data; everything else is 0.
module cache_arbiter_datapath
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              sel_i,
  input  logic              sel_d,
  input  logic [ADDR_W-1:0] ic_address,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [LINE_W-1:0] ic_wdata,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic [ADDR_W-1:0] dc_address,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  always_comb begin
    l2_address = '0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_wdata   = '0;
    ic_rdata   = '0;
    ic_resp    = 1'b0;
    dc_rdata   = '0;
    dc_resp    = 1'b0;
    // A simultaneous read+write is treated as a write.
    unique case (1'b1)
      sel_d: begin
        l2_address = dc_address;
        l2_write   = dc_write;
        l2_read    = dc_read & ~dc_write;
        l2_wdata   = dc_wdata;
        dc_rdata   = l2_rdata;
        dc_resp    = l2_resp;
      end
      sel_i: begin
        l2_address = ic_address;
        l2_write   = ic_write;
        l2_read    = ic_read & ~ic_write;
        l2_wdata   = ic_wdata;
        ic_rdata   = l2_rdata;
        ic_resp    = l2_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache miss paths onto one L2 port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is dc priority.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_address,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [LINE_W-1:0] ic_wdata,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic [ADDR_W-1:0] dc_address,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              busy
);

  arb_state_t state_q, state_d;
  logic       ic_req, dc_req, dc_wins;

  assign ic_req = ic_read | ic_write;
  assign dc_req = dc_read | dc_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D-cache was granted last.
  logic last_grant_q, last_grant_d;

  assign dc_wins = dc_req & (~ic_req | ~last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && state_d == GRANT_D) last_grant_d = 1'b1;
    if (state_q == IDLE && state_d == GRANT_I) last_grant_d = 1'b0;
  end
`else
  assign dc_wins = dc_req;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dc_wins)     state_d = GRANT_D;
        else if (ic_req) state_d = GRANT_I;
      end
      GRANT_I: if (l2_resp) state_d = DONE;
      GRANT_D: if (l2_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);

  cache_arbiter_datapath #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_dp (
    .sel_i     (state_q == GRANT_I),
    .sel_d     (state_q == GRANT_D),
    .ic_address(ic_address),
    .ic_read   (ic_read),
    .ic_write  (ic_write),
    .ic_wdata  (ic_wdata),
    .ic_rdata  (ic_rdata),
    .ic_resp   (ic_resp),
    .dc_address(dc_address),
    .dc_read   (dc_read),
    .dc_write  (dc_write),
    .dc_wdata  (dc_wdata),
    .dc_rdata  (dc_rdata),
    .dc_resp   (dc_resp),
    .l2_address(l2_address),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_resp   (l2_resp)
  );

`ifndef SYNTHESIS
  a_rw_both: assert property (@(posedge clk) disable iff (rst)
    !((ic_read && ic_write) || (dc_read && dc_write)))
    else $warning("arbiter: read and write high together");

  a_drop_i: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT_I) |-> ic_req)
    else $warning("arbiter: ic request dropped before resp");

  a_drop_d: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT_D) |-> dc_req)
    else $warning("arbiter: dc request dropped before resp");

  a_stray: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE || state_q == DONE) |-> !l2_resp)
    else $warning("arbiter: stray l2_resp ignored");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized self-checking bench for cache_arbiter.
// Expectations come from a transaction-level model of the arbitration rules.
module tb_cache_arbiter;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ic_address = '0, dc_address = '0, l2_address;
  logic        ic_read = 0, ic_write = 0, dc_read = 0, dc_write = 0;
  lc3b_line    ic_wdata = '0, dc_wdata = '0, l2_rdata = '0;
  lc3b_line    ic_rdata, dc_rdata, l2_wdata;
  logic        ic_resp, dc_resp, l2_read, l2_write, l2_resp = 0, busy;

  int errors = 0;
  int checks = 0;
  bit model_last = 1'b0;

  cache_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .ic_address(ic_address), .ic_read(ic_read), .ic_write(ic_write),
    .ic_wdata(ic_wdata), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_address(dc_address), .dc_read(dc_read), .dc_write(dc_write),
    .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic lc3b_line rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // 1 = D-cache wins
  function automatic bit pick(bit ir, bit dr);
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !model_last;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_cycle(input int lat, input lc3b_line line,
                             input bit raise_ic, output bit obs_d);
    bit       w, ew, er;
    logic [15:0] ea;
    lc3b_line ewd;
    w   = pick(ic_read | ic_write, dc_read | dc_write);
    ea  = w ? dc_address : ic_address;
    ew  = w ? dc_write : ic_write;
    er  = (w ? dc_read : ic_read) & ~ew;
    ewd = w ? dc_wdata : ic_wdata;
    model_last = w;
    obs_d = 1'b0;
    tick();
    if (raise_ic) begin
      ic_read = 1; ic_write = 0; ic_address = 16'($urandom);
    end
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) begin
        l2_resp = 1; l2_rdata = line;
      end else l2_rdata = rand_line();
      #3;
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL grant_busy got=%b exp=1", busy);
      end
      checks++;
      if (l2_read !== er) begin
        errors++; $display("FAIL l2_read got=%b exp=%b", l2_read, er);
      end
      checks++;
      if (l2_write !== ew) begin
        errors++; $display("FAIL l2_write got=%b exp=%b", l2_write, ew);
      end
      checks++;
      if (l2_address !== ea) begin
        errors++; $display("FAIL l2_address got=%h exp=%h", l2_address, ea);
      end
      if (ew) begin
        checks++;
        if (l2_wdata !== ewd) begin
          errors++; $display("FAIL l2_wdata got=%h exp=%h", l2_wdata, ewd);
        end
      end
      if (c == lat) begin
        obs_d = dc_resp;
        checks++;
        if ({ic_resp, dc_resp} !== {~w, w}) begin
          errors++;
          $display("FAIL resp_route got=%b%b exp=%b%b",
                   ic_resp, dc_resp, ~w, w);
        end
        checks++;
        if ((w ? dc_rdata : ic_rdata) !== line) begin
          errors++;
          $display("FAIL rdata_pass got=%h exp=%h",
                   w ? dc_rdata : ic_rdata, line);
        end
        checks++;
        if ((w ? ic_rdata : dc_rdata) !== '0) begin
          errors++;
          $display("FAIL rdata_other got=%h exp=0",
                   w ? ic_rdata : dc_rdata);
        end
      end else begin
        checks++;
        if ({ic_resp, dc_resp} !== 2'b00) begin
          errors++;
          $display("FAIL early_resp got=%b%b exp=00", ic_resp, dc_resp);
        end
      end
      tick();
    end
    l2_resp = 0;
    #3;
    checks++;
    if ({busy, l2_read, l2_write, ic_resp, dc_resp} !== 5'b10000) begin
      errors++;
      $display("FAIL done_state got=%b exp=10000",
               {busy, l2_read, l2_write, ic_resp, dc_resp});
    end
  endtask

  task automatic idle_step();
    tick();
    #3;
    checks++;
    if ({busy, l2_read, l2_write} !== 3'b000) begin
      errors++;
      $display("FAIL idle_state got=%b exp=000", {busy, l2_read, l2_write});
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    #2;
    checks++;
    if ({l2_read, l2_write, ic_resp, dc_resp, busy} !== 5'b0 ||
        l2_address !== '0 || l2_wdata !== '0 ||
        ic_rdata !== '0 || dc_rdata !== '0) begin
      errors++;
      $display("FAIL reset_vals got=%b%b%b%b%b addr=%h exp=0",
               l2_read, l2_write, ic_resp, dc_resp, busy, l2_address);
    end
    rst = 0;
    model_last = 0;
    tick();
  endtask

  task automatic test_single_read();
    bit d;
    ic_read = 1; ic_address = 16'h1230;
    grant_cycle(4, {16{8'hA5}}, 0, d);
    ic_read = 0;
    idle_step();
    idle_step();
  endtask

  task automatic test_simultaneous();
    bit d;
    ic_read = 1; ic_address = 16'($urandom);
    dc_write = 1; dc_address = 16'h4000; dc_wdata = rand_line();
    grant_cycle(int'($urandom_range(1, 4)), rand_line(), 0, d);
    if (d) dc_write = 0; else ic_read = 0;
    idle_step();
    grant_cycle(int'($urandom_range(1, 4)), rand_line(), 0, d);
    ic_read = 0; dc_write = 0;
    idle_step();
  endtask

  task automatic test_mid_arrival();
    bit d;
    dc_read = 1; dc_address = 16'h0010;
    grant_cycle(3, rand_line(), 1, d);
    dc_read = 0;
    idle_step();
    grant_cycle(int'($urandom_range(1, 4)), rand_line(), 0, d);
    ic_read = 0;
    idle_step();
  endtask

  task automatic test_reset_mid();
    dc_read = 1; dc_address = 16'($urandom);
    l2_rdata = rand_line();
    tick();
    tick();
    #2;
    checks++;
    if (l2_read !== 1'b1) begin
      errors++; $display("FAIL pre_rst_read got=%b exp=1", l2_read);
    end
    rst = 1;
    #1;
    checks++;
    if ({l2_read, l2_write, busy, dc_resp, ic_resp} !== 5'b0 ||
        l2_address !== '0 || dc_rdata !== '0) begin
      errors++;
      $display("FAIL async_rst got=%b%b%b addr=%h exp=0",
               l2_read, l2_write, busy, l2_address);
    end
    dc_read = 0;
    model_last = 0;
    tick();
    rst = 0;
    tick();
    l2_resp = 1; l2_rdata = rand_line();
    #3;
    checks++;
    if ({ic_resp, dc_resp} !== 2'b00 || dc_rdata !== '0) begin
      errors++;
      $display("FAIL post_rst_stray got=%b%b exp=00", ic_resp, dc_resp);
    end
    tick();
    l2_resp = 0;
    #3;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL post_rst_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_rw_both();
    bit d;
    dc_read = 1; dc_write = 1;
    dc_address = 16'($urandom); dc_wdata = rand_line();
    grant_cycle(2, rand_line(), 0, d);
    dc_read = 0; dc_write = 0;
    idle_step();
  endtask

  task automatic test_stray();
    l2_resp = 1; l2_rdata = rand_line();
    #3;
    checks++;
    if ({ic_resp, dc_resp} !== 2'b00 || ic_rdata !== '0) begin
      errors++;
      $display("FAIL stray_resp got=%b%b exp=00", ic_resp, dc_resp);
    end
    tick();
    l2_resp = 0;
    #3;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stray_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    bit d, prev;
    int nd = 0, ni = 0;
    ic_read = 1; ic_address = 16'($urandom);
    dc_write = 1; dc_address = 16'($urandom); dc_wdata = rand_line();
    for (int t = 0; t < 20; t++) begin
      grant_cycle(int'($urandom_range(1, 3)), rand_line(), 0, d);
      if (d) nd++; else ni++;
`ifdef ARB_ROUND_ROBIN_EN
      if (t > 0) begin
        checks++;
        if (d === prev) begin
          errors++; $display("FAIL rr_alternate got=%b prev=%b", d, prev);
        end
      end
`else
      checks++;
      if (d !== 1'b1) begin
        errors++; $display("FAIL fixed_prio got=%b exp=1", d);
      end
`endif
      prev = d;
      if (d) begin
        dc_address = dc_address ^ 16'(1 + $urandom_range(0, 254));
        dc_write = 1'($urandom); dc_read = ~dc_write;
        dc_wdata = rand_line();
      end else begin
        ic_address = ic_address ^ 16'(1 + $urandom_range(0, 254));
        ic_read = 1;
      end
      idle_step();
    end
`ifdef ARB_ROUND_ROBIN_EN
    checks++;
    if (nd != 10 || ni != 10) begin
      errors++; $display("FAIL rr_counts got=%0d/%0d exp=10/10", nd, ni);
    end
`else
    checks++;
    if (nd != 20 || ni != 0) begin
      errors++; $display("FAIL fixed_counts got=%0d/%0d exp=20/0", nd, ni);
    end
`endif
    dc_read = 0; dc_write = 0;
    tick();
    if (ic_read) begin
      grant_cycle(2, rand_line(), 0, d);
      ic_read = 0;
      idle_step();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_mid_arrival();
    test_reset_mid();
    test_rw_both();
    test_simultaneous();
    test_stray();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
